// File: rtl/bsg_async_credit_return_sched_pkg.sv
// bsg_async_credit_sched_pkg: shared state encoding and width helper for the credit return scheduler
package bsg_async_credit_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, MARGIN = 2'd1, RUN = 2'd2} state_e;
    function automatic int popcount_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/bsg_async_credit_return_sched_popcount.sv
// bsg_credit_popcount: counts how many requesters return a credit this cycle
module bsg_credit_popcount
    import bsg_async_credit_sched_pkg::*;
#(
    parameter int num_req_p = 4
) (
    input  logic [num_req_p-1:0]                    v_i,
    output logic [popcount_width(num_req_p)-1:0]    cnt_o
);
    localparam int cnt_w_lp = popcount_width(num_req_p);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < num_req_p; i++)
            cnt_o = cnt_o + cnt_w_lp'(v_i[i]);
    end
endmodule

// File: rtl/bsg_async_credit_return_sched.sv
// bsg_async_credit_return_sched: accumulates returned credits and emits rate-limited token pulses,
// optionally preceded by a burst of margin tokens after reset
module bsg_async_credit_return_sched
    import bsg_async_credit_sched_pkg::*;
#(
    parameter int num_req_p                       = 4,
    parameter int lg_credit_to_token_decimation_p = 0,
    parameter int margin_tokens_p                 = 0,
    parameter int min_gap_p                       = 1,
    parameter int acc_width_p                     = 8
) (
    input  logic                   w_clk_i,
    input  logic                   w_reset_i,
    input  logic                   en_i,
    input  logic [num_req_p-1:0]   req_credit_v_i,
    output logic                   w_inc_token_o,
    output logic [acc_width_p-1:0] pending_credits_o,
    output logic                   margin_done_o,
    output logic                   overflow_o
);
    localparam int cnt_w_lp = popcount_width(num_req_p);
    localparam int mw_lp    = margin_tokens_p > 0 ? $clog2(margin_tokens_p + 1) : 1;
    localparam int gw_lp    = min_gap_p > 1 ? $clog2(min_gap_p) : 1;
    localparam logic [acc_width_p:0] tok_lp = (acc_width_p + 1)'(1 << lg_credit_to_token_decimation_p);
    localparam logic [acc_width_p:0] max_lp = {1'b0, {acc_width_p{1'b1}}};
    localparam logic [gw_lp-1:0]     gap_reload_lp = gw_lp'(min_gap_p - 1);

    state_e                 state_q;
    logic [acc_width_p-1:0] acc_q, acc_d;
    logic [gw_lp-1:0]       gap_cnt_q;
    logic [mw_lp-1:0]       margin_cnt_q;
    logic                   tok_q, ovf_q, mdone_q;
    logic [cnt_w_lp-1:0]    arrivals;
    logic [acc_width_p:0]   sum;
    logic                   issue_margin, issue_run, last_margin, sat;

    bsg_credit_popcount #(.num_req_p(num_req_p)) u_pop (.v_i(req_credit_v_i), .cnt_o(arrivals));

    always_comb begin
        issue_margin = state_q == MARGIN && en_i && gap_cnt_q == '0;
        issue_run    = state_q == RUN && en_i && gap_cnt_q == '0 && {1'b0, acc_q} >= tok_lp;
        last_margin  = int'(margin_cnt_q) == margin_tokens_p - 1;
        // issue_run implies acc >= TOK, so the subtraction never wraps
        sum          = {1'b0, acc_q} + (acc_width_p + 1)'(arrivals) - (issue_run ? tok_lp : '0);
        sat          = sum > max_lp;
        acc_d        = sat ? '1 : sum[acc_width_p-1:0];
    end

    always_ff @(posedge w_clk_i or posedge w_reset_i) begin
        if (w_reset_i) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            gap_cnt_q    <= '0;
            margin_cnt_q <= '0;
            tok_q        <= 1'b0;
            ovf_q        <= 1'b0;
            mdone_q      <= margin_tokens_p == 0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_q | sat;
            tok_q     <= issue_margin | issue_run;
            gap_cnt_q <= (issue_margin | issue_run) ? gap_reload_lp
                       : gap_cnt_q != '0 ? gap_cnt_q - 1'b1 : gap_cnt_q;
            if (issue_margin)
                margin_cnt_q <= margin_cnt_q + 1'b1;
            case (state_q)
                IDLE:    if (en_i) state_q <= margin_tokens_p > 0 ? MARGIN : RUN;
                MARGIN:  if (issue_margin && last_margin) begin
                             state_q <= RUN;
                             mdone_q <= 1'b1;
                         end
                default: ;
            endcase
        end
    end

    assign w_inc_token_o     = tok_q;
    assign pending_credits_o = acc_q;
    assign margin_done_o     = mdone_q;
    assign overflow_o        = ovf_q;
endmodule

// File: tb/tb_bsg_async_credit_return_sched.sv
// tb_bsg_async_credit_return_sched: five differently-configured instances exercised in turn;
// expected token pulses (instance, cycle) are queued by stimulus and matched by a monitor
module tb_bsg_async_credit_return_sched;
    typedef struct {int inst; int cyc;} exp_t;

    logic       clk;
    logic       rst[5];
    logic       en[5];
    logic [3:0] req[5];
    logic       tok[5];
    logic [7:0] pend[5];
    logic [3:0] pend_e;
    logic       mdone[5];
    logic       ovf[5];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    exp_t       exp_q[$];

    assign pend[4] = {4'b0, pend_e};

    // A: lg=0 margin=0 gap=1
    bsg_async_credit_return_sched #(.num_req_p(4), .lg_credit_to_token_decimation_p(0), .margin_tokens_p(0),
        .min_gap_p(1), .acc_width_p(8)) u_a (.w_clk_i(clk), .w_reset_i(rst[0]), .en_i(en[0]),
        .req_credit_v_i(req[0]), .w_inc_token_o(tok[0]), .pending_credits_o(pend[0]),
        .margin_done_o(mdone[0]), .overflow_o(ovf[0]));
    // B: TOK=4
    bsg_async_credit_return_sched #(.num_req_p(4), .lg_credit_to_token_decimation_p(2), .margin_tokens_p(0),
        .min_gap_p(1), .acc_width_p(8)) u_b (.w_clk_i(clk), .w_reset_i(rst[1]), .en_i(en[1]),
        .req_credit_v_i(req[1]), .w_inc_token_o(tok[1]), .pending_credits_o(pend[1]),
        .margin_done_o(mdone[1]), .overflow_o(ovf[1]));
    // C: 3 margin tokens, gap=2
    bsg_async_credit_return_sched #(.num_req_p(4), .lg_credit_to_token_decimation_p(0), .margin_tokens_p(3),
        .min_gap_p(2), .acc_width_p(8)) u_c (.w_clk_i(clk), .w_reset_i(rst[2]), .en_i(en[2]),
        .req_credit_v_i(req[2]), .w_inc_token_o(tok[2]), .pending_credits_o(pend[2]),
        .margin_done_o(mdone[2]), .overflow_o(ovf[2]));
    // D: gap=3
    bsg_async_credit_return_sched #(.num_req_p(4), .lg_credit_to_token_decimation_p(0), .margin_tokens_p(0),
        .min_gap_p(3), .acc_width_p(8)) u_d (.w_clk_i(clk), .w_reset_i(rst[3]), .en_i(en[3]),
        .req_credit_v_i(req[3]), .w_inc_token_o(tok[3]), .pending_credits_o(pend[3]),
        .margin_done_o(mdone[3]), .overflow_o(ovf[3]));
    // E: 4-bit accumulator
    bsg_async_credit_return_sched #(.num_req_p(4), .lg_credit_to_token_decimation_p(0), .margin_tokens_p(0),
        .min_gap_p(1), .acc_width_p(4)) u_e (.w_clk_i(clk), .w_reset_i(rst[4]), .en_i(en[4]),
        .req_credit_v_i(req[4]), .w_inc_token_o(tok[4]), .pending_credits_o(pend_e),
        .margin_done_o(mdone[4]), .overflow_o(ovf[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (tok[i]) begin
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: inst %0d at cycle %0d, none expected", i, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.inst != i || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL pulse_timing: got inst %0d cycle %0d, expected inst %0d cycle %0d",
                                 i, cyc, e.inst, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int inst, input int c);
        exp_t e;
        e.inst = inst;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    initial begin
        int s;
        for (int i = 0; i < 5; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b0;
            req[i] = 4'h0;
        end
        tick(2);
        for (int i = 0; i < 5; i++) rst[i] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("reset_pending", int'(pend[i]), 0);
            chk("reset_token", int'(tok[i]), 0);
            chk("reset_overflow", int'(ovf[i]), 0);
            chk("reset_margin_done", int'(mdone[i]), i == 2 ? 0 : 1);
        end

        // single credit -> one pulse two cycles later
        en[0] = 1'b1;
        tick();
        s = cyc;
        req[0] = 4'h1;
        push(0, s + 2);
        tick();
        req[0] = 4'h0;
        chk("t1_pending_one", int'(pend[0]), 1);
        tick();
        chk("t1_pending_zero", int'(pend[0]), 0);
        tick(2);

        // decimation by 4
        en[1] = 1'b1;
        tick();
        req[1] = 4'h7;
        tick();
        req[1] = 4'h0;
        tick(3);
        chk("t2_pending_three", int'(pend[1]), 3);
        s = cyc;
        req[1] = 4'h1;
        push(1, s + 2);
        tick();
        req[1] = 4'h0;
        tick();
        chk("t2_pending_after_token", int'(pend[1]), 0);
        s = cyc;
        req[1] = 4'hf;
        push(1, s + 2);
        tick();
        req[1] = 4'h1;
        tick();
        req[1] = 4'h0;
        chk("t2_pending_net", int'(pend[1]), 1);
        tick(3);
        chk("t2_pending_residual", int'(pend[1]), 1);

        // margin tokens spaced by gap=2
        s = cyc;
        en[2] = 1'b1;
        push(2, s + 2);
        push(2, s + 4);
        push(2, s + 6);
        tick(5);
        chk("t3_margin_not_done", int'(mdone[2]), 0);
        tick();
        chk("t3_margin_done", int'(mdone[2]), 1);
        tick(6);

        // all requesters for 5 cycles, gap=3
        en[3] = 1'b1;
        tick();
        s = cyc;
        req[3] = 4'hf;
        for (int k = 0; k < 20; k++) push(3, s + 2 + 3 * k);
        tick(3);
        chk("t4_acc_mid", int'(pend[3]), 11);
        tick(2);
        req[3] = 4'h0;
        chk("t4_acc_peak", int'(pend[3]), 18);
        tick(57);
        chk("t4_acc_drained", int'(pend[3]), 0);

        // saturation with issue disabled, then drain
        req[4] = 4'hf;
        tick(5);
        req[4] = 4'h0;
        chk("t5_saturated", int'(pend[4]), 15);
        chk("t5_overflow", int'(ovf[4]), 1);
        s = cyc;
        en[4] = 1'b1;
        for (int k = 0; k < 15; k++) push(4, s + 2 + k);
        tick(17);
        chk("t5_drained", int'(pend[4]), 0);
        chk("t5_overflow_sticky", int'(ovf[4]), 1);

        // async reset mid-pulse with acc=6, then margin restart
        en[2] = 1'b0;
        req[2] = 4'hf;
        tick();
        req[2] = 4'h3;
        tick();
        req[2] = 4'h1;
        en[2] = 1'b1;
        tick();
        req[2] = 4'h0;
        chk("t6_pulse_before_reset", int'(tok[2]), 1);
        chk("t6_acc_before_reset", int'(pend[2]), 6);
        #2;
        rst[2] = 1'b1;
        #1;
        chk("t6_token_cleared", int'(tok[2]), 0);
        chk("t6_pending_cleared", int'(pend[2]), 0);
        chk("t6_overflow_cleared", int'(ovf[2]), 0);
        chk("t6_margin_done_cleared", int'(mdone[2]), 0);
        tick();
        rst[2] = 1'b0;
        s = cyc;
        push(2, s + 2);
        push(2, s + 4);
        push(2, s + 6);
        tick(6);
        chk("t6_margin_done_again", int'(mdone[2]), 1);
        tick(4);

        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bsg_async_credit_return_sched.md
Name: bsg_async_credit_return_sched

Overview:
Write-side (w_) credit return scheduler that drives the w_inc_token input of an async credit counter. It collects single-credit returns from num_req_p downstream buffer slices into a shared accumulator and decimates them into tokens worth 2^lg_credit_to_token_decimation_p credits. It emits at most one registered token pulse per min_gap_p cycles, to bound the toggle rate on the token wire. After reset it can optionally issue margin_tokens_p extra tokens to enlarge the upstream credit window.

Parameters:
num_req_p, 4, number of credit-returning requesters (>=1)
lg_credit_to_token_decimation_p, 0, log2 of credits per token; must equal the setting of the receiving credit counter
margin_tokens_p, 0, tokens issued unconditionally after reset, before normal operation
min_gap_p, 1, minimum cycles between token pulse rising edges (>=1; 1 = back-to-back allowed)
acc_width_p, 8, credit accumulator width; must be > lg_credit_to_token_decimation_p

Ports:
w_clk_i  in  1  write-domain clock; all state on posedge
w_reset_i  in  1  reset: asynchronous, active-high; clock w_clk_i
en_i  in  1  enables token issue (accumulation continues when low)
req_credit_v_i  in  num_req_p  bit k=1: requester k returns one credit this cycle
w_inc_token_o  out  1  registered one-cycle token pulse to the credit counter
pending_credits_o  out  acc_width_p  current accumulator value
margin_done_o  out  1  high once all margin tokens have been issued
overflow_o  out  1  sticky: accumulator saturated; cleared only by reset

Behaviour:
- Reset (async assert, sync release): state=IDLE, acc=0, gap_cnt=0, margin_cnt=0, w_inc_token_o=0, overflow_o=0, margin_done_o=(margin_tokens_p==0).
- TOK = 2^lg_credit_to_token_decimation_p. arrivals = popcount(req_credit_v_i), width $clog2(num_req_p+1).
- States:
  - IDLE -> MARGIN when en_i=1 and margin_tokens_p>0.
  - IDLE -> RUN when en_i=1 and margin_tokens_p==0.
  - MARGIN -> RUN in the cycle the last margin token issues.
  - RUN is terminal until reset.
- issue_margin = state==MARGIN & en_i & gap_cnt==0. Does not consume acc. Increments margin_cnt.
- issue_run = state==RUN & en_i & gap_cnt==0 & acc>=TOK.
- issue = issue_margin | issue_run.
- On the edge where issue=1:
  - w_inc_token_o<=1 for exactly one cycle.
  - gap_cnt<=min_gap_p-1.
  - Otherwise w_inc_token_o<=0, and gap_cnt decrements if nonzero.
- Latency: credits arriving at edge t are visible in acc after t. Earliest resulting pulse is high in the cycle after t+1 (2-cycle return-to-pulse latency).
- Accumulator: acc_next = acc + arrivals - (issue_run ? TOK : 0), computed at acc_width_p+1 bits.
  - Arrivals in IDLE/MARGIN accumulate normally.
  - Simultaneous arrival and issue use the net value; no credit is lost.
  - If acc_next > 2^acc_width_p-1: acc saturates at max and overflow_o<=1 (sticky).
- Credits below TOK stay in acc indefinitely; no partial tokens are ever sent.
- en_i low: issue suppressed, gap_cnt still counts down, state holds (except IDLE stays IDLE).
- margin_done_o rises on the edge that leaves MARGIN, or stays 1 from reset if margin_tokens_p==0.
- Reset asserted mid-operation immediately clears everything, including any in-flight pulse. Pending credits are discarded by design: the counter's reset procedure resets both sides.
- w_inc_token_o is always a flop output; no combinational path from inputs.

Decomposition:
- Package bsg_async_credit_sched_pkg holds the state enum (IDLE, MARGIN, RUN; 2 bits) and the width helper for popcount.
- One sub-module, bsg_credit_popcount (num_req_p-wide one-hot-sum adder tree, combinational).
- The FSM, accumulator, and gap counter live in the top module.

Test Plan:
1. Reset, en_i=1, lg=0, margin=0, gap=1; pulse req bit0 once -> one w_inc_token_o pulse 2 cycles later; pending_credits_o back to 0.
2. lg=2 (TOK=4); 3 credits -> no pulse, pending=3; 4th credit -> one pulse, pending=0; 9 credits total -> 2 pulses, pending=1.
3. margin_tokens_p=3, gap=2, no arrivals -> 3 pulses spaced exactly 2 cycles apart; margin_done_o rises with the third; no further pulses.
4. num_req_p=4, all bits high for 5 cycles, lg=0, gap=3 -> acc peaks correctly; pulses every 3rd cycle; net acc always equals sum(arrivals)-pulses.
5. acc_width_p=4, en_i=0, 20 credits -> pending saturates at 15, overflow_o=1 and stays 1 after en_i=1 drains.
6. Assert w_reset_i asynchronously mid-pulse with acc=6 -> w_inc_token_o, pending, overflow clear immediately; FSM in IDLE; next en_i restarts margin sequence.
